// File: rtl/riscv_v_pkg.sv
// Shared types and constants for the RISC-V V register file and scoreboard.
package riscv_v_pkg;

    localparam int RISCV_V_NUM_REGS        = 32;
    localparam int RISCV_V_VLEN            = 128;
    localparam int RISCV_V_ID_2_WB_LATENCY = 3;
    localparam int RISCV_V_MAX_INFLIGHT    = RISCV_V_ID_2_WB_LATENCY + 1;
    localparam int RISCV_V_SB_CNT_W        = $clog2(RISCV_V_MAX_INFLIGHT + 1);

    typedef logic [$clog2(RISCV_V_NUM_REGS)-1:0] riscv_v_rf_addr_t;
    typedef logic [RISCV_V_VLEN/8-1:0]           riscv_v_rf_wr_en_t;
    typedef logic [RISCV_V_VLEN-1:0]             riscv_v_data_t;
    typedef logic [RISCV_V_SB_CNT_W-1:0]         riscv_v_sb_cnt_t;

    // A counter is busy while any write to its register is unretired.
    function automatic logic sb_busy(input riscv_v_sb_cnt_t cnt);
        return (cnt != {RISCV_V_SB_CNT_W{1'b0}});
    endfunction

endpackage

// File: rtl/riscv_v_rf_if.sv
// ID/WB-side bundle of the vector register file: issue, read ports, write-back.
interface riscv_v_rf_if;
    import riscv_v_pkg::*;

    logic                        flush;
    logic                        issue_valid;
    logic                        issue_wr;
    riscv_v_rf_addr_t            issue_addr;
    riscv_v_rf_addr_t            rd_addr_a;
    riscv_v_rf_addr_t            rd_addr_b;
    logic                        rd_used_a;
    logic                        rd_used_b;
    riscv_v_data_t               rd_data_a;
    riscv_v_data_t               rd_data_b;
    logic                        hazard_a;
    logic                        hazard_b;
    logic                        wr_retire;
    riscv_v_rf_addr_t            wr_addr;
    riscv_v_rf_wr_en_t           wr_en;
    riscv_v_data_t               wr_data;
    logic [RISCV_V_NUM_REGS-1:0] pending;

    // Pipeline side: drives issue, read addresses and write-back.
    modport master (
        output flush, issue_valid, issue_wr, issue_addr,
        output rd_addr_a, rd_addr_b, rd_used_a, rd_used_b,
        output wr_retire, wr_addr, wr_en, wr_data,
        input  rd_data_a, rd_data_b, hazard_a, hazard_b, pending
    );

    // Register file side.
    modport slave (
        input  flush, issue_valid, issue_wr, issue_addr,
        input  rd_addr_a, rd_addr_b, rd_used_a, rd_used_b,
        input  wr_retire, wr_addr, wr_en, wr_data,
        output rd_data_a, rd_data_b, hazard_a, hazard_b, pending
    );
endinterface

// File: rtl/riscv_v_rf_sb_chk.sv
// Simulation checker: no issue into a full counter, no retire from an empty one.
module riscv_v_rf_sb_chk #(
    parameter int NUM_REGS     = 32,
    parameter int MAX_INFLIGHT = 4,
    parameter int CW           = 3
) (
    input logic                         clk,
    input logic                         rst,
    input logic                         flush,
    input logic [NUM_REGS-1:0]          inc,
    input logic [NUM_REGS-1:0]          dec,
    input logic [NUM_REGS-1:0][CW-1:0]  cnt
);
    // Flag illegal counter transitions on every active edge outside reset and flush.
    always @(posedge clk) begin
        if (rst && !flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                assert (!(inc[i] && !dec[i] && (cnt[i] == CW'(MAX_INFLIGHT))))
                    else $error("scoreboard overflow on v%0d", i);
                assert (!(dec[i] && !inc[i] && (cnt[i] == {CW{1'b0}})))
                    else $error("scoreboard underflow on v%0d", i);
            end
        end
    end
endmodule

// File: rtl/riscv_v_rf_scoreboard.sv
// Per-register in-flight write counters, pending flags and RAW hazard detection.
module riscv_v_rf_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int MAX_INFLIGHT = 4,
    parameter int AW           = $clog2(NUM_REGS),
    parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        issue_valid,
    input  logic                        issue_wr,
    input  logic [AW-1:0]               issue_addr,
    input  logic                        wr_retire,
    input  logic [AW-1:0]               wr_addr,
    input  logic [AW-1:0]               rd_addr_a,
    input  logic [AW-1:0]               rd_addr_b,
    input  logic                        rd_used_a,
    input  logic                        rd_used_b,
    output logic                        hazard_a,
    output logic                        hazard_b,
    output logic [NUM_REGS-1:0]         pending,
    output logic [NUM_REGS-1:0]         inc_s,
    output logic [NUM_REGS-1:0]         dec_s,
    output logic [NUM_REGS-1:0][CW-1:0] cnt_q
);
    logic [NUM_REGS-1:0][CW-1:0] cnt_d;
    logic [CW-1:0]               cnt_a_s;
    logic [CW-1:0]               cnt_b_s;

    // Decode issue and retire into per-register increment/decrement strobes.
    always_comb begin
        inc_s = '0;
        dec_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_s[i] = issue_valid & issue_wr & (issue_addr == AW'(i));
            dec_s[i] = wr_retire & (wr_addr == AW'(i));
        end
    end

    // Next counter values: flush clears, otherwise saturating +/-1.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (flush) begin
                cnt_d[i] = {CW{1'b0}};
            end else if (inc_s[i] && !dec_s[i] && (cnt_q[i] != CW'(MAX_INFLIGHT))) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (dec_s[i] && !inc_s[i] && (cnt_q[i] != {CW{1'b0}})) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Counter state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Pending flags and hazards; the last producer retiring now is covered by bypass.
    always_comb begin
        cnt_a_s = cnt_q[rd_addr_a];
        cnt_b_s = cnt_q[rd_addr_b];
        for (int i = 0; i < NUM_REGS; i++) begin
            pending[i] = (cnt_q[i] != {CW{1'b0}});
        end
        hazard_a = rd_used_a & (cnt_a_s != {CW{1'b0}})
                 & ~((cnt_a_s == CW'(1)) & wr_retire & (wr_addr == rd_addr_a));
        hazard_b = rd_used_b & (cnt_b_s != {CW{1'b0}})
                 & ~((cnt_b_s == CW'(1)) & wr_retire & (wr_addr == rd_addr_b));
    end
endmodule

// File: rtl/riscv_v_rf.sv
// Vector register file: byte-masked storage with write-through read bypass
// and a write scoreboard feeding the ID stall logic.
module riscv_v_rf
    import riscv_v_pkg::*;
#(
    parameter int NUM_REGS     = RISCV_V_NUM_REGS,
    parameter int VLEN         = RISCV_V_VLEN,
    parameter int MAX_INFLIGHT = RISCV_V_ID_2_WB_LATENCY + 1
) (
    input logic         clk,
    input logic         rst,
    riscv_v_rf_if.slave rf
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int NB = VLEN / 8;
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [NUM_REGS-1:0][VLEN-1:0] mem_q;
    logic [NUM_REGS-1:0][VLEN-1:0] mem_d;
    logic [NUM_REGS-1:0]           inc_s;
    logic [NUM_REGS-1:0]           dec_s;
    logic [NUM_REGS-1:0][CW-1:0]   cnt_s;

    // Byte-masked write into the addressed register; enables act without retire.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NB; j++) begin
            mem_d[rf.wr_addr][j*8 +: 8] = rf.wr_en[j] ? rf.wr_data[j*8 +: 8]
                                                      : mem_q[rf.wr_addr][j*8 +: 8];
        end
    end

    // Storage register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read ports: stored value with same-cycle write bytes forwarded in.
    always_comb begin
        rf.rd_data_a = mem_q[rf.rd_addr_a];
        rf.rd_data_b = mem_q[rf.rd_addr_b];
        for (int j = 0; j < NB; j++) begin
            rf.rd_data_a[j*8 +: 8] = (rf.wr_en[j] && (rf.wr_addr == rf.rd_addr_a))
                                   ? rf.wr_data[j*8 +: 8] : mem_q[rf.rd_addr_a][j*8 +: 8];
            rf.rd_data_b[j*8 +: 8] = (rf.wr_en[j] && (rf.wr_addr == rf.rd_addr_b))
                                   ? rf.wr_data[j*8 +: 8] : mem_q[rf.rd_addr_b][j*8 +: 8];
        end
    end

    riscv_v_rf_scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .AW           (AW),
        .CW           (CW)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .flush       (rf.flush),
        .issue_valid (rf.issue_valid),
        .issue_wr    (rf.issue_wr),
        .issue_addr  (rf.issue_addr),
        .wr_retire   (rf.wr_retire),
        .wr_addr     (rf.wr_addr),
        .rd_addr_a   (rf.rd_addr_a),
        .rd_addr_b   (rf.rd_addr_b),
        .rd_used_a   (rf.rd_used_a),
        .rd_used_b   (rf.rd_used_b),
        .hazard_a    (rf.hazard_a),
        .hazard_b    (rf.hazard_b),
        .pending     (rf.pending),
        .inc_s       (inc_s),
        .dec_s       (dec_s),
        .cnt_q       (cnt_s)
    );

    riscv_v_rf_sb_chk #(
        .NUM_REGS     (NUM_REGS),
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CW           (CW)
    ) u_sb_chk (
        .clk   (clk),
        .rst   (rst),
        .flush (rf.flush),
        .inc   (inc_s),
        .dec   (dec_s),
        .cnt   (cnt_s)
    );
endmodule

// File: tb/tb_riscv_v_rf.sv
// Directed self-checking bench for riscv_v_rf.
module tb_riscv_v_rf;
    import riscv_v_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    riscv_v_rf_if rf_if ();

    riscv_v_rf dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf_if)
    );

    localparam logic [127:0] ALL_A5 = {16{8'hA5}};
    localparam logic [127:0] PART   = {{15{8'hA5}}, 8'h11};
    localparam logic [127:0] PAT7   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] PAT9   = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rf_if.flush       = 1'b0;
        rf_if.issue_valid = 1'b0;
        rf_if.issue_wr    = 1'b0;
        rf_if.issue_addr  = '0;
        rf_if.rd_used_a   = 1'b0;
        rf_if.rd_used_b   = 1'b0;
        rf_if.wr_retire   = 1'b0;
        rf_if.wr_addr     = '0;
        rf_if.wr_en       = '0;
        rf_if.wr_data     = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rf_if.rd_addr_a = 5'd5;
        rf_if.rd_addr_b = 5'd5;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        rf_if.rd_used_a = 1'b1;
        rf_if.rd_used_b = 1'b1;
        step();
        tests_run++;
        if (rf_if.rd_data_a !== 128'h0) begin
            tests_failed++; $display("FAIL reset_rd_a got %h exp 0", rf_if.rd_data_a);
        end
        tests_run++;
        if (rf_if.rd_data_b !== 128'h0) begin
            tests_failed++; $display("FAIL reset_rd_b got %h exp 0", rf_if.rd_data_b);
        end
        tests_run++;
        if ({rf_if.hazard_a, rf_if.hazard_b} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_hazard got %b exp 00", {rf_if.hazard_a, rf_if.hazard_b});
        end
        tests_run++;
        if (rf_if.pending !== 32'h0) begin
            tests_failed++; $display("FAIL reset_pending got %h exp 0", rf_if.pending);
        end
    endtask

    task automatic test_full_write();
        idle_inputs();
        rf_if.wr_addr   = 5'd3;
        rf_if.wr_en     = 16'hFFFF;
        rf_if.wr_data   = ALL_A5;
        rf_if.rd_addr_a = 5'd3;
        rf_if.rd_addr_b = 5'd4;
        #1;
        tests_run++;
        if (rf_if.rd_data_a !== ALL_A5) begin
            tests_failed++; $display("FAIL bypass_full got %h exp %h", rf_if.rd_data_a, ALL_A5);
        end
        tests_run++;
        if (rf_if.rd_data_b !== 128'h0) begin
            tests_failed++; $display("FAIL bypass_other_reg got %h exp 0", rf_if.rd_data_b);
        end
        step();
        idle_inputs();
        rf_if.rd_addr_b = 5'd3;
        #1;
        tests_run++;
        if (rf_if.rd_data_a !== ALL_A5) begin
            tests_failed++; $display("FAIL stored_full got %h exp %h", rf_if.rd_data_a, ALL_A5);
        end
        tests_run++;
        if (rf_if.rd_data_b !== ALL_A5) begin
            tests_failed++; $display("FAIL stored_full_b got %h exp %h", rf_if.rd_data_b, ALL_A5);
        end
    endtask

    task automatic test_partial_write();
        idle_inputs();
        rf_if.wr_addr   = 5'd3;
        rf_if.wr_en     = 16'h0001;
        rf_if.wr_data   = 128'h11;
        rf_if.rd_addr_a = 5'd3;
        #1;
        tests_run++;
        if (rf_if.rd_data_a !== PART) begin
            tests_failed++; $display("FAIL bypass_partial got %h exp %h", rf_if.rd_data_a, PART);
        end
        step();
        idle_inputs();
        #1;
        tests_run++;
        if (rf_if.rd_data_a !== PART) begin
            tests_failed++; $display("FAIL stored_partial got %h exp %h", rf_if.rd_data_a, PART);
        end
    endtask

    task automatic test_hazard();
        idle_inputs();
        rf_if.issue_valid = 1'b1;
        rf_if.issue_wr    = 1'b1;
        rf_if.issue_addr  = 5'd7;
        rf_if.rd_addr_a   = 5'd7;
        rf_if.rd_used_a   = 1'b1;
        #1;
        tests_run++;
        if (rf_if.hazard_a !== 1'b0) begin
            tests_failed++; $display("FAIL hazard_issue_cycle got %b exp 0", rf_if.hazard_a);
        end
        step();
        rf_if.issue_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests_run++;
            if (rf_if.hazard_a !== 1'b1 || rf_if.pending !== 32'h0000_0080) begin
                tests_failed++;
                $display("FAIL hazard_wait%0d got hz=%b pend=%h exp hz=1 pend=00000080", c, rf_if.hazard_a, rf_if.pending);
            end
            step();
        end
        rf_if.rd_used_a = 1'b0;
        #1;
        tests_run++;
        if (rf_if.hazard_a !== 1'b0) begin
            tests_failed++; $display("FAIL hazard_unused got %b exp 0", rf_if.hazard_a);
        end
        rf_if.rd_used_a = 1'b1;
        rf_if.wr_retire = 1'b1;
        rf_if.wr_addr   = 5'd7;
        rf_if.wr_en     = 16'hFFFF;
        rf_if.wr_data   = PAT7;
        #1;
        tests_run++;
        if (rf_if.hazard_a !== 1'b0 || rf_if.rd_data_a !== PAT7) begin
            tests_failed++;
            $display("FAIL retire_bypass got hz=%b data=%h exp hz=0 data=%h", rf_if.hazard_a, rf_if.rd_data_a, PAT7);
        end
        step();
        idle_inputs();
        rf_if.rd_used_a = 1'b1;
        #1;
        tests_run++;
        if (rf_if.pending !== 32'h0 || rf_if.hazard_a !== 1'b0 || rf_if.rd_data_a !== PAT7) begin
            tests_failed++;
            $display("FAIL after_retire got pend=%h hz=%b data=%h exp pend=0 hz=0 data=%h", rf_if.pending, rf_if.hazard_a, rf_if.rd_data_a, PAT7);
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        rf_if.rd_addr_a   = 5'd7;
        rf_if.rd_used_a   = 1'b1;
        rf_if.issue_valid = 1'b1;
        rf_if.issue_wr    = 1'b1;
        rf_if.issue_addr  = 5'd7;
        step();
        step();
        rf_if.issue_valid = 1'b0;
        rf_if.wr_retire   = 1'b1;
        rf_if.wr_addr     = 5'd7;
        #1;
        tests_run++;
        if (rf_if.hazard_a !== 1'b1) begin
            tests_failed++; $display("FAIL b2b_first_retire got %b exp 1", rf_if.hazard_a);
        end
        step();
        rf_if.wr_retire = 1'b0;
        #1;
        tests_run++;
        if (rf_if.hazard_a !== 1'b1 || rf_if.pending !== 32'h0000_0080) begin
            tests_failed++;
            $display("FAIL b2b_one_left got hz=%b pend=%h exp hz=1 pend=00000080", rf_if.hazard_a, rf_if.pending);
        end
        rf_if.wr_retire = 1'b1;
        #1;
        tests_run++;
        if (rf_if.hazard_a !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_second_retire got %b exp 0", rf_if.hazard_a);
        end
        step();
        rf_if.wr_retire = 1'b0;
        #1;
        tests_run++;
        if (rf_if.pending !== 32'h0) begin
            tests_failed++; $display("FAIL b2b_drained got %h exp 0", rf_if.pending);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        rf_if.issue_valid = 1'b1;
        rf_if.issue_wr    = 1'b1;
        rf_if.issue_addr  = 5'd2;
        step();
        rf_if.issue_addr  = 5'd4;
        step();
        rf_if.issue_valid = 1'b0;
        #1;
        tests_run++;
        if (rf_if.pending !== 32'h0000_0014) begin
            tests_failed++; $display("FAIL flush_before got %h exp 00000014", rf_if.pending);
        end
        rf_if.flush       = 1'b1;
        rf_if.issue_valid = 1'b1;
        rf_if.issue_addr  = 5'd6;
        rf_if.wr_addr     = 5'd9;
        rf_if.wr_en       = 16'hFFFF;
        rf_if.wr_data     = PAT9;
        step();
        idle_inputs();
        rf_if.rd_addr_a = 5'd9;
        #1;
        tests_run++;
        if (rf_if.pending !== 32'h0) begin
            tests_failed++; $display("FAIL flush_after got %h exp 0", rf_if.pending);
        end
        tests_run++;
        if (rf_if.rd_data_a !== PAT9) begin
            tests_failed++; $display("FAIL flush_write got %h exp %h", rf_if.rd_data_a, PAT9);
        end
    endtask

    task automatic test_reset_midflight();
        idle_inputs();
        rf_if.issue_valid = 1'b1;
        rf_if.issue_wr    = 1'b1;
        rf_if.issue_addr  = 5'd10;
        step();
        rf_if.issue_valid = 1'b0;
        #1;
        tests_run++;
        if (rf_if.pending !== 32'h0000_0400) begin
            tests_failed++; $display("FAIL midreset_before got %h exp 00000400", rf_if.pending);
        end
        rst = 1'b0;
        rf_if.issue_valid = 1'b1;
        rf_if.issue_addr  = 5'd11;
        rf_if.wr_addr     = 5'd12;
        rf_if.wr_en       = 16'hFFFF;
        rf_if.wr_data     = PAT7;
        step();
        rst = 1'b1;
        idle_inputs();
        rf_if.rd_addr_a = 5'd3;
        rf_if.rd_addr_b = 5'd9;
        #1;
        tests_run++;
        if (rf_if.pending !== 32'h0) begin
            tests_failed++; $display("FAIL midreset_pending got %h exp 0", rf_if.pending);
        end
        tests_run++;
        if (rf_if.rd_data_a !== 128'h0 || rf_if.rd_data_b !== 128'h0) begin
            tests_failed++; $display("FAIL midreset_storage got a=%h b=%h exp 0", rf_if.rd_data_a, rf_if.rd_data_b);
        end
        rf_if.rd_addr_a = 5'd12;
        #1;
        tests_run++;
        if (rf_if.rd_data_a !== 128'h0) begin
            tests_failed++; $display("FAIL midreset_write_blocked got %h exp 0", rf_if.rd_data_a);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        rf_if.rd_addr_a = '0;
        rf_if.rd_addr_b = '0;
        idle_inputs();
        test_reset();
        test_full_write();
        test_partial_write();
        test_hazard();
        test_back_to_back();
        test_flush();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
